// File: rtl/time_to_bcd.sv
// Purpose: iterative seconds-of-day to HH:MM:SS BCD converter, one subtraction step per cycle.
// Latency: done pulses (W+1)+(H+1)+(M+1)+(T+1) edges after the start-accept edge (min 4, 91 worst in-range).
// Backpressure: start is taken only in IDLE; any start while busy is dropped, never queued.
module time_to_bcd #(
  parameter int IN_W        = 32,
  parameter int SEC_PER_DAY = 86400
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [IN_W-1:0] seconds_in,
  output logic            busy,
  output logic            done,
  output logic [23:0]     bcd,
  output logic            wrapped
);

  localparam logic [IN_W-1:0] DAY_S  = IN_W'(SEC_PER_DAY);
  localparam logic [IN_W-1:0] HOUR_S = IN_W'(3600);
  localparam logic [IN_W-1:0] MIN_S  = IN_W'(60);

  typedef enum logic [2:0] {IDLE, WRAP, HOUR, MIN, SPLIT, DONE} state_t;

  state_t          state;
  logic [IN_W-1:0] rem;
  logic            wrap_flag;
  // binary hour/minute/second values, reduced by 10 per step during SPLIT
  logic [4:0]      h;
  logic [5:0]      m;
  logic [5:0]      s;
  // tens counters built up during SPLIT
  logic [1:0]      ht;
  logic [2:0]      mt;
  logic [2:0]      st;

  // conversion sequencer: capture, modulo-day, hours, minutes, decimal split, publish
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rem       <= '0;
      wrap_flag <= 1'b0;
      h         <= '0;
      m         <= '0;
      s         <= '0;
      ht        <= '0;
      mt        <= '0;
      st        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      wrapped   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem       <= seconds_in;
            h         <= '0;
            m         <= '0;
            wrap_flag <= 1'b0;
            busy      <= 1'b1;
            state     <= WRAP;
          end
        end
        WRAP: begin
          if (rem >= DAY_S) begin
            rem       <= rem - DAY_S;
            wrap_flag <= 1'b1;
          end else begin
            state <= HOUR;
          end
        end
        HOUR: begin
          if (rem >= HOUR_S) begin
            rem <= rem - HOUR_S;
            h   <= h + 5'd1;
          end else begin
            state <= MIN;
          end
        end
        MIN: begin
          if (rem >= MIN_S) begin
            rem <= rem - MIN_S;
            m   <= m + 6'd1;
          end else begin
            // remainder is below 60 here, so six bits hold it exactly
            s     <= rem[5:0];
            ht    <= '0;
            mt    <= '0;
            st    <= '0;
            state <= SPLIT;
          end
        end
        SPLIT: begin
          if (h < 5'd10 && m < 6'd10 && s < 6'd10) begin
            bcd     <= {2'b00, ht, h[3:0], 1'b0, mt, m[3:0], 1'b0, st, s[3:0]};
            wrapped <= wrap_flag;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            if (h >= 5'd10) begin
              h  <= h - 5'd10;
              ht <= ht + 2'd1;
            end
            if (m >= 6'd10) begin
              m  <= m - 6'd10;
              mt <= mt + 3'd1;
            end
            if (s >= 6'd10) begin
              s  <= s - 6'd10;
              st <= st + 3'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_to_bcd.sv
// Directed bench for time_to_bcd: reset values, conversion results and latency,
// modulo-day wrap, ignored start while busy, back-to-back starts, reset abort.
module tb_time_to_bcd;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [31:0] seconds_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic        wrapped;

  int total = 0;
  int bad   = 0;

  time_to_bcd #(.IN_W(32), .SEC_PER_DAY(86400)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .seconds_in (seconds_in),
    .busy       (busy),
    .done       (done),
    .bcd        (bcd),
    .wrapped    (wrapped)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Present start for one edge (edge 0), then count edges until done is seen.
  task automatic run_conv(input logic [31:0] sec, output int edges, output logic got);
    @(negedge CLK);
    start      = 1'b1;
    seconds_in = sec;
    @(posedge CLK);
    #1;
    start = 1'b0;
    edges = 0;
    got   = 1'b0;
    for (int i = 1; i <= 300 && !got; i++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        got   = 1'b1;
        edges = i;
      end
    end
  endtask

  task automatic test_reset;
    RST        = 1'b1;
    start      = 1'b0;
    seconds_in = '0;
    #12;
    total++; if (bcd !== 24'h000000) begin bad++; $display("FAIL reset_bcd got=%h exp=%h", bcd, 24'h000000); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL reset_wrapped got=%b exp=0", wrapped); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_zero;
    int   e;
    logic g;
    run_conv(32'd0, e, g);
    total++; if (g !== 1'b1 || e != 4) begin bad++; $display("FAIL zero_latency got=%0d (seen=%b) exp=4", e, g); end
    total++; if (bcd !== 24'h000000) begin bad++; $display("FAIL zero_bcd got=%h exp=000000", bcd); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL zero_wrapped got=%b exp=0", wrapped); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_in_done got=%b exp=1", busy); end
    @(posedge CLK); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_after_done got done=%b busy=%b exp 0 0", done, busy); end
  endtask

  task automatic test_mid;
    int   e;
    logic g;
    run_conv(32'd45296, e, g);
    total++; if (g !== 1'b1 || e != 55) begin bad++; $display("FAIL mid_latency got=%0d (seen=%b) exp=55", e, g); end
    total++; if (bcd !== 24'h123456) begin bad++; $display("FAIL mid_bcd got=%h exp=123456", bcd); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL mid_wrapped got=%b exp=0", wrapped); end
    repeat (3) @(posedge CLK);
    #1;
    total++; if (bcd !== 24'h123456) begin bad++; $display("FAIL mid_bcd_hold got=%h exp=123456", bcd); end
  endtask

  task automatic test_max;
    int   e;
    logic g;
    run_conv(32'd86399, e, g);
    total++; if (g !== 1'b1 || e != 91) begin bad++; $display("FAIL max_latency got=%0d (seen=%b) exp=91", e, g); end
    total++; if (bcd !== 24'h235959) begin bad++; $display("FAIL max_bcd got=%h exp=235959", bcd); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL max_wrapped got=%b exp=0", wrapped); end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_wrap;
    int   e;
    logic g;
    run_conv(32'd90000, e, g);
    total++; if (g !== 1'b1 || e != 6) begin bad++; $display("FAIL wrap90000_latency got=%0d (seen=%b) exp=6", e, g); end
    total++; if (bcd !== 24'h010000) begin bad++; $display("FAIL wrap90000_bcd got=%h exp=010000", bcd); end
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL wrap90000_wrapped got=%b exp=1", wrapped); end
    repeat (2) @(posedge CLK);
    run_conv(32'd86400, e, g);
    total++; if (g !== 1'b1 || e != 5) begin bad++; $display("FAIL wrap86400_latency got=%0d (seen=%b) exp=5", e, g); end
    total++; if (bcd !== 24'h000000) begin bad++; $display("FAIL wrap86400_bcd got=%h exp=000000", bcd); end
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL wrap86400_wrapped got=%b exp=1", wrapped); end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_ignore_start;
    int   ndone;
    int   first;
    int   e;
    logic g;
    @(negedge CLK);
    start      = 1'b1;
    seconds_in = 32'd45296;
    @(posedge CLK);
    #1;
    start      = 1'b0;
    seconds_in = 32'd0;
    ndone = 0;
    first = 0;
    for (int i = 1; i <= 120; i++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        ndone++;
        if (first == 0) first = i;
      end
      // pulses land on edges 3 and 5
      start = (i == 2 || i == 4);
    end
    start = 1'b0;
    total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    total++; if (first != 55) begin bad++; $display("FAIL ignore_latency got=%0d exp=55", first); end
    total++; if (bcd !== 24'h123456) begin bad++; $display("FAIL ignore_bcd got=%h exp=123456", bcd); end
    run_conv(32'd0, e, g);
    total++; if (g !== 1'b1 || e != 4) begin bad++; $display("FAIL ignore_restart_latency got=%0d (seen=%b) exp=4", e, g); end
    total++; if (bcd !== 24'h000000) begin bad++; $display("FAIL ignore_restart_bcd got=%h exp=000000", bcd); end
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_back_to_back;
    int d1;
    int d2;
    @(negedge CLK);
    start      = 1'b1;
    seconds_in = 32'd90000;
    @(posedge CLK);
    d1 = 0;
    d2 = 0;
    for (int i = 1; i <= 40 && d2 == 0; i++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        if (d1 == 0) d1 = i;
        else d2 = i;
      end
    end
    start = 1'b0;
    total++; if (d1 != 6) begin bad++; $display("FAIL b2b_first_done got=%0d exp=6", d1); end
    total++; if (d2 != 14) begin bad++; $display("FAIL b2b_second_done got=%0d exp=14", d2); end
    total++; if (bcd !== 24'h010000 || wrapped !== 1'b1) begin bad++; $display("FAIL b2b_result got bcd=%h wrapped=%b exp 010000 1", bcd, wrapped); end
    repeat (12) @(posedge CLK);
  endtask

  task automatic test_reset_mid;
    int   e;
    int   ndone;
    int   nbusy;
    logic g;
    run_conv(32'd90000, e, g);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    start      = 1'b1;
    seconds_in = 32'd45296;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    total++; if (bcd !== 24'h000000) begin bad++; $display("FAIL rstmid_bcd got=%h exp=000000", bcd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL rstmid_wrapped got=%b exp=0", wrapped); end
    @(negedge CLK);
    RST = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
    total++; if (nbusy != 0) begin bad++; $display("FAIL rstmid_stays_idle got=%0d busy cycles exp=0", nbusy); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_mid();
    test_max();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
